// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared sizing defaults and fetch-state encoding for the PC fetch controller,
// the branch-target LUT and the instruction memory.
package pc_fetch_ctrl_pkg;

  localparam int PC_W_DEF  = 7;   // 128-word instruction memory
  localparam int CNT_W_DEF = 16;  // retired-instruction counter

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Combinational next-PC select: halt > taken branch > sequential, with
// end-of-memory detection instead of wrapping past the last address.
module pc_next_sel #(
  parameter int PC_W = 7
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_halt,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_end_of_mem
);

  logic w_at_top;
  assign w_at_top = &i_pc;

  always_comb begin
    o_next_pc    = i_pc + 1'b1;
    o_end_of_mem = 1'b0;
    if (i_halt) begin
      o_next_pc = i_pc;
    end else if (i_branch_taken) begin
      o_next_pc = i_branch_target;
    end else if (w_at_top) begin
      // falling off the end holds the PC and is reported, never wraps
      o_next_pc    = i_pc;
      o_end_of_mem = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE/RUN/HALTED sequencing, branch/stall
// handling, overflow flag and saturating retired-instruction count.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic             pc_ovf,
  output logic [CNT_W-1:0] icount
);

  fetch_state_e     r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt, w_sel_pc;
  logic [CNT_W-1:0] r_icount, w_icount_nxt, w_icount_inc;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, r_done;
  logic             w_end_of_mem;

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .i_pc            (r_pc),
    .i_halt          (halt),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_next_pc       (w_sel_pc),
    .o_end_of_mem    (w_end_of_mem)
  );

  assign w_icount_inc = (&r_icount) ? r_icount : r_icount + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_icount_nxt = r_icount;
    w_ovf_nxt    = r_ovf;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          w_state_nxt  = ST_RUN;
          w_pc_nxt     = start_addr;
          w_icount_nxt = '0;
          w_ovf_nxt    = 1'b0;
        end
      end
      ST_RUN: begin
        // a stalled cycle retires nothing, whatever halt/branch say
        if (!stall) begin
          w_pc_nxt     = w_sel_pc;
          w_icount_nxt = w_icount_inc;
          if (halt || w_end_of_mem) w_state_nxt = ST_HALTED;
          if (w_end_of_mem)         w_ovf_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_icount <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_icount <= w_icount_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_done   <= (w_state_nxt == ST_HALTED);
    end
  end

  assign pc     = r_pc;
  assign busy   = r_busy;
  assign done   = r_done;
  assign pc_ovf = r_ovf;
  assign icount = r_icount;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each scenario pushes the expected
// registered outputs as it drives a cycle and pops/compares after the edge.
module tb_pc_fetch_ctrl;

  localparam int PC_W  = 7;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, stall, branch_taken, halt;
  logic [PC_W-1:0]  start_addr, branch_target;
  logic [PC_W-1:0]  pc;
  logic             busy, done, pc_ovf;
  logic [CNT_W-1:0] icount;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [CNT_W-1:0] ic;
  } exp_t;

  typedef struct packed {
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] sa;
    logic            stall;
    logic            bt;
    logic [PC_W-1:0] tgt;
    logic            halt;
    exp_t            e;
  } row_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miss = 0;

  pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc),
    .busy          (busy),
    .done          (done),
    .pc_ovf        (pc_ovf),
    .icount        (icount)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", vecs);
    $fatal(1, "timeout");
  end

  function automatic row_t R(int rs, int st, int sa, int stl, int bt, int tgt, int hl,
                             int epc, int ebusy, int edone, int eovf, int eic);
    row_t r;
    r.rst_n = rs[0];  r.start = st[0];  r.sa = sa[PC_W-1:0];
    r.stall = stl[0]; r.bt = bt[0];     r.tgt = tgt[PC_W-1:0]; r.halt = hl[0];
    r.e.pc = epc[PC_W-1:0]; r.e.busy = ebusy[0]; r.e.done = edone[0];
    r.e.ovf = eovf[0];      r.e.ic = eic[CNT_W-1:0];
    return r;
  endfunction

  task automatic drive(input row_t r);
    rst_n = r.rst_n; start = r.start; start_addr = r.sa; stall = r.stall;
    branch_taken = r.bt; branch_target = r.tgt; halt = r.halt;
  endtask

  task automatic test_reset();
    row_t t[$];
    exp_t e, got;
    // reset wins over every control input, then IDLE holds with start low
    t.push_back(R(0,1,9,0,1,3,1, 0,0,0,0,0));
    t.push_back(R(0,1,9,0,1,3,1, 0,0,0,0,0));
    t.push_back(R(1,0,9,0,1,3,1, 0,0,0,0,0));
    t.push_back(R(1,0,0,1,0,0,0, 0,0,0,0,0));
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL reset step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  task automatic test_seq_halt();
    row_t t[$];
    exp_t e, got;
    t.push_back(R(1,1,0,0,0,0,0, 0,1,0,0,0));
    for (int p = 1; p <= 5; p++) t.push_back(R(1,0,0,0,0,0,0, p,1,0,0,p));
    t.push_back(R(1,0,0,0,0,0,1, 5,0,1,0,6));
    t.push_back(R(1,0,0,0,1,9,1, 5,0,1,0,6));
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL seq_halt step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  task automatic test_branch();
    row_t t[$];
    exp_t e, got;
    t.push_back(R(1,1,10,0,0,0,0, 10,1,0,0,0));
    t.push_back(R(1,0,0,0,1,15,0, 15,1,0,0,1));
    t.push_back(R(1,1,3,0,0,0,0,  16,1,0,0,2));   // start ignored while running
    t.push_back(R(1,0,0,0,0,0,0,  17,1,0,0,3));
    t.push_back(R(1,0,0,0,1,18,0, 18,1,0,0,4));
    t.push_back(R(1,0,0,0,1,2,1,  18,0,1,0,5));   // halt beats branch
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL branch step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  task automatic test_stall();
    row_t t[$];
    exp_t e, got;
    t.push_back(R(1,1,20,0,0,0,0, 20,1,0,0,0));
    t.push_back(R(1,0,0,0,0,0,0,  21,1,0,0,1));
    t.push_back(R(1,0,0,1,1,26,0, 21,1,0,0,1));
    t.push_back(R(1,0,0,1,1,26,0, 21,1,0,0,1));
    t.push_back(R(1,0,0,1,1,26,1, 21,1,0,0,1));
    t.push_back(R(1,0,0,0,1,26,0, 26,1,0,0,2));
    t.push_back(R(1,0,0,0,0,0,1,  26,0,1,0,3));
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL stall step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  task automatic test_overflow();
    row_t t[$];
    exp_t e, got;
    t.push_back(R(1,1,125,0,0,0,0, 125,1,0,0,0));
    t.push_back(R(1,0,0,0,0,0,0,   126,1,0,0,1));
    t.push_back(R(1,0,0,0,0,0,0,   127,1,0,0,2));
    t.push_back(R(1,0,0,0,0,0,0,   127,0,1,1,3));
    t.push_back(R(1,0,0,0,0,0,0,   127,0,1,1,3));
    // branch out of the last address is legal and clears nothing but needs no flag
    t.push_back(R(1,1,126,0,0,0,0, 126,1,0,0,0));
    t.push_back(R(1,0,0,0,0,0,0,   127,1,0,0,1));
    t.push_back(R(1,0,0,0,1,3,0,   3,1,0,0,2));
    t.push_back(R(1,0,0,0,0,0,1,   3,0,1,0,3));
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL overflow step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    row_t t[$];
    exp_t e, got;
    t.push_back(R(1,1,19,0,0,0,0, 19,1,0,0,0));
    t.push_back(R(0,1,5,0,1,30,1, 0,0,0,0,0));
    t.push_back(R(1,0,0,0,0,0,0,  0,0,0,0,0));
    t.push_back(R(1,1,0,0,0,0,0,  0,1,0,0,0));
    t.push_back(R(1,0,0,0,0,0,1,  0,0,1,0,1));
    t.push_back(R(1,1,7,0,0,0,0,  7,1,0,0,0));
    t.push_back(R(1,0,0,0,0,0,1,  7,0,1,0,1));
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL reset_mid_run step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  task automatic test_saturate();
    row_t t[$];
    exp_t e, got;
    int   max_ic = (1 << CNT_W) - 1;
    // branch-to-self long enough to pin the counter at its maximum
    t.push_back(R(1,1,40,0,0,0,0, 40,1,0,0,0));
    for (int i = 1; i <= max_ic + 5; i++)
      t.push_back(R(1,0,0,0,1,40,0, 40,1,0,0, (i > max_ic) ? max_ic : i));
    t.push_back(R(1,0,0,0,0,0,1, 40,0,1,0,max_ic));
    foreach (t[k]) begin
      drive(t[k]); sb.push_back(t[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); got = {pc, busy, done, pc_ovf, icount}; vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL saturate step %0d: got pc=%0d busy=%b done=%b ovf=%b ic=%0d want pc=%0d busy=%b done=%b ovf=%b ic=%0d",
                 k, got.pc, got.busy, got.done, got.ovf, got.ic, e.pc, e.busy, e.done, e.ovf, e.ic);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    @(negedge clk);
    test_reset();
    test_seq_halt();
    test_branch();
    test_stall();
    test_overflow();
    test_reset_mid_run();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
